kernel_launch_queue: RTL and testbench

- Front-end launch controller for the gpu core, replacing static kernel-config wiring at the top level.
- Accepts kernel launch descriptors over a valid/ready interface and buffers them in a parametrised FIFO.
- Issues them to the gpu one at a time, holding the active kernel_config stable for the whole run.
- Adds a per-kernel watchdog, skips zero-block launches, and reports busy, queue, completion and timeout status.

---
 rtl/kernel_launch_queue.sv | 142 ++++++++++++++
 tb/tb_kernel_launch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launch_queue.sv
// rtl/kernel_launch_queue.sv - queued kernel launch controller with per-kernel watchdog
`ifndef INSTRUCTION_MEMORY_ADDRESS_WIDTH
`define INSTRUCTION_MEMORY_ADDRESS_WIDTH 8
`endif
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package kernel_launch_pkg;
  localparam int INSTR_AW = `INSTRUCTION_MEMORY_ADDRESS_WIDTH;
  localparam int DATA_AW  = `DATA_MEMORY_ADDRESS_WIDTH;
  localparam int DATA_W   = `DATA_WIDTH;

  typedef struct packed {
    logic [INSTR_AW-1:0] base_instructions_address;
    logic [DATA_AW-1:0]  base_data_address;
    logic [DATA_W-1:0]   num_blocks;
    logic [DATA_W-1:0]   num_warps_per_block;
  } kernel_config_t;
endpackage

module kernel_launch_queue
  import kernel_launch_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           submit_valid,
  output logic                           submit_ready,
  input  logic [INSTR_AW-1:0]            submit_base_instructions_address,
  input  logic [DATA_AW-1:0]             submit_base_data_address,
  input  logic [DATA_W-1:0]              submit_num_blocks,
  input  logic [DATA_W-1:0]              submit_num_warps_per_block,
  output kernel_config_t                 kernel_config,
  output logic                           execution_start,
  input  logic                           execution_done,
  output logic                           kernel_abort,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic [COUNT_WIDTH-1:0]         completed_count,
  output logic                           timeout_error,
  input  logic                           clear_error
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t          state, state_next;
  kernel_config_t  mem [QUEUE_DEPTH];
  kernel_config_t  head, submit_desc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [WD_W-1:0]  wd_cnt, wd_next;
  logic             push, pop, retire, timeout_fire;

  assign submit_desc = {submit_base_instructions_address, submit_base_data_address,
                        submit_num_blocks, submit_num_warps_per_block};
  assign head         = mem[rd_ptr];
  assign submit_ready = (count < DEPTH_C);
  assign push         = submit_valid && submit_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign queue_count  = count;
  assign execution_start = (state == RUN);
  assign busy         = (count != '0) || (state != IDLE);

  always_comb begin
    state_next   = state;
    wd_next      = wd_cnt;
    retire       = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          wd_next = '0;
          // Zero-block launches retire immediately without ever starting the gpu.
          if (head.num_blocks == '0) retire = 1'b1;
          else state_next = RUN;
        end
      end
      RUN: begin
        wd_next = wd_cnt + WD_W'(1);
        if (execution_done) begin
          state_next = RELEASE;
          retire     = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
          state_next   = RELEASE;
          retire       = 1'b1;
          timeout_fire = 1'b1;
        end
      end
      RELEASE: begin
        if (!execution_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wd_cnt          <= '0;
      kernel_config   <= '0;
      completed_count <= '0;
      kernel_abort    <= 1'b0;
      timeout_error   <= 1'b0;
    end else begin
      state        <= state_next;
      wd_cnt       <= wd_next;
      kernel_abort <= timeout_fire;
      if (push) begin
        mem[wr_ptr] <= submit_desc;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        kernel_config <= head;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (retire) completed_count <= completed_count + COUNT_WIDTH'(1);
      // A fresh timeout outranks a simultaneous clear.
      if (timeout_fire)     timeout_error <= 1'b1;
      else if (clear_error) timeout_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kernel_launch_queue.sv
// tb/tb_kernel_launch_queue.sv - randomized and directed bench for kernel_launch_queue
module tb_kernel_launch_queue;
  import kernel_launch_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 24;
  localparam int CW    = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 submit_valid;
  logic                 submit_ready;
  logic [INSTR_AW-1:0]  submit_base_instructions_address;
  logic [DATA_AW-1:0]   submit_base_data_address;
  logic [DATA_W-1:0]    submit_num_blocks;
  logic [DATA_W-1:0]    submit_num_warps_per_block;
  kernel_config_t       kernel_config;
  logic                 execution_start;
  logic                 execution_done;
  logic                 kernel_abort;
  logic                 busy;
  logic [$clog2(DEPTH):0] queue_count;
  logic [CW-1:0]        completed_count;
  logic                 timeout_error;
  logic                 clear_error;

  always #5 clk = ~clk;

  kernel_launch_queue #(
    .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .submit_valid(submit_valid), .submit_ready(submit_ready),
    .submit_base_instructions_address(submit_base_instructions_address),
    .submit_base_data_address(submit_base_data_address),
    .submit_num_blocks(submit_num_blocks),
    .submit_num_warps_per_block(submit_num_warps_per_block),
    .kernel_config(kernel_config), .execution_start(execution_start),
    .execution_done(execution_done), .kernel_abort(kernel_abort),
    .busy(busy), .queue_count(queue_count), .completed_count(completed_count),
    .timeout_error(timeout_error), .clear_error(clear_error)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending descriptors plus the active launch's phase.
  kernel_config_t mq[$];
  kernel_config_t m_cfg = '0;
  bit          m_run = 0, m_rel = 0, m_abort = 0, m_terr = 0;
  int          m_run_cnt = 0;
  int unsigned m_done = 0;

  bit auto_gpu = 0;
  int gpu_lat = 0, gpu_hold = 0;

  task automatic model_edge();
    kernel_config_t d;
    bit acc, tmo;
    if (!reset) begin
      mq.delete();
      m_run = 0; m_rel = 0; m_cfg = '0; m_done = 0; m_terr = 0; m_abort = 0;
      return;
    end
    tmo = 0;
    acc = submit_valid && (mq.size() < DEPTH);
    d = {submit_base_instructions_address, submit_base_data_address,
         submit_num_blocks, submit_num_warps_per_block};
    m_abort = 0;
    if (!m_run && !m_rel) begin
      if (mq.size() != 0) begin
        m_cfg = mq.pop_front();
        if (m_cfg.num_blocks == 0) m_done++;
        else begin m_run = 1; m_run_cnt = 0; end
      end
    end else if (m_run) begin
      if (execution_done) begin
        m_run = 0; m_rel = 1; m_done++;
      end else if (TMO != 0 && m_run_cnt == TMO - 1) begin
        m_run = 0; m_rel = 1; m_done++; m_abort = 1; tmo = 1;
      end else m_run_cnt++;
    end else if (!execution_done) m_rel = 0;
    if (tmo) m_terr = 1;
    else if (clear_error) m_terr = 0;
    if (acc) mq.push_back(d);
  endtask

  task automatic gpu_drive();
    if (m_run) begin
      if (m_run_cnt == 0) begin
        gpu_lat  = $urandom_range(0, TMO + 4);
        gpu_hold = $urandom_range(0, 2);
      end
      execution_done = (m_run_cnt >= gpu_lat);
    end else if (m_rel) begin
      if (execution_done) begin
        if (gpu_hold == 0) execution_done = 0;
        else gpu_hold--;
      end
    end else execution_done = 0;
  endtask

  task automatic compare_all();
    check("start", 64'(execution_start), 64'(m_run));
    check("abort", 64'(kernel_abort), 64'(m_abort));
    check("busy", 64'(busy), 64'((mq.size() != 0) || m_run || m_rel));
    check("queue_count", 64'(queue_count), 64'(mq.size()));
    check("ready", 64'(submit_ready), 64'(mq.size() < DEPTH));
    check("completed", 64'(completed_count), 64'(m_done % (1 << CW)));
    check("timeout_error", 64'(timeout_error), 64'(m_terr));
    check("kernel_config", 64'(kernel_config), 64'(m_cfg));
  endtask

  task automatic step();
    if (auto_gpu) gpu_drive();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_desc(input int i, input int d, input int b, input int w);
    submit_base_instructions_address = INSTR_AW'(i);
    submit_base_data_address         = DATA_AW'(d);
    submit_num_blocks                = DATA_W'(b);
    submit_num_warps_per_block       = DATA_W'(w);
  endtask

  task automatic do_reset();
    reset = 0; submit_valid = 0; execution_done = 0; clear_error = 0; auto_gpu = 0;
    step();
    reset = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (mq.size() != 0 || m_run || m_rel); i++) step();
    check("drain_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    reset = 0; submit_valid = 0; execution_done = 0; clear_error = 0;
    set_desc(0, 0, 0, 0);

    do_reset();
    check("rst_count", 64'(queue_count), 64'(0));
    check("rst_ready", 64'(submit_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_completed", 64'(completed_count), 64'(0));

    // Single launch
    set_desc(8'h10, 8'h40, 2, 1); submit_valid = 1; step(); submit_valid = 0;
    check("sl_start_early", 64'(execution_start), 64'(0));
    step();
    check("sl_start", 64'(execution_start), 64'(1));
    check("sl_cfg", 64'(kernel_config), 64'(32'h10400201));
    repeat (20) step();
    execution_done = 1; step();
    check("sl_start_drop", 64'(execution_start), 64'(0));
    check("sl_completed", 64'(completed_count), 64'(1));
    check("sl_busy_release", 64'(busy), 64'(1));
    execution_done = 0; step();
    check("sl_busy_done", 64'(busy), 64'(0));

    // Back-pressure with a stalled gpu
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_desc(8'h20 + k, 8'h80 + k, k + 1, 1); submit_valid = 1; step();
    end
    set_desc(8'h25, 8'h85, 6, 1);
    repeat (3) step();
    check("bp_count", 64'(queue_count), 64'(4));
    check("bp_ready", 64'(submit_ready), 64'(0));
    check("bp_start", 64'(execution_start), 64'(1));
    gpu_lat = 0; auto_gpu = 1;
    for (int i = 0; i < 400 && submit_valid; i++) begin
      if (mq.size() < DEPTH) begin step(); submit_valid = 0; end
      else step();
    end
    check("bp_sixth_accepted", 64'(submit_valid), 64'(0));
    drain();
    check("bp_completed", 64'(completed_count), 64'(6));

    // Zero-block skip
    do_reset();
    set_desc(1, 2, 0, 1); submit_valid = 1; step();
    set_desc(3, 4, 3, 1); step(); submit_valid = 0;
    check("zb_completed", 64'(completed_count), 64'(1));
    check("zb_no_start", 64'(execution_start), 64'(0));
    step();
    check("zb_start", 64'(execution_start), 64'(1));
    execution_done = 1; step(); execution_done = 0; step();
    check("zb_completed2", 64'(completed_count), 64'(2));

    // Watchdog expiry, clear, and done on the last cycle
    do_reset();
    set_desc(5, 6, 1, 1); submit_valid = 1; step(); submit_valid = 0;
    n = 0;
    for (int i = 0; i < TMO + 10; i++) begin
      step();
      if (execution_start) n++;
      else if (n > 0) break;
    end
    check("wd_len", 64'(n), 64'(TMO));
    check("wd_abort", 64'(kernel_abort), 64'(1));
    check("wd_err", 64'(timeout_error), 64'(1));
    step();
    check("wd_abort_pulse", 64'(kernel_abort), 64'(0));
    check("wd_err_sticky", 64'(timeout_error), 64'(1));
    clear_error = 1; step(); clear_error = 0;
    check("wd_clear", 64'(timeout_error), 64'(0));
    submit_valid = 1; step(); submit_valid = 0; step();
    repeat (TMO - 1) step();
    execution_done = 1; step();
    check("wd_done_wins_abort", 64'(kernel_abort), 64'(0));
    check("wd_done_wins_err", 64'(timeout_error), 64'(0));
    execution_done = 0; step();

    // Handshake corners: full queue at pop, and push+pop at count 2
    do_reset();
    for (int k = 0; k < 5; k++) begin set_desc(k, k, 1, 1); submit_valid = 1; step(); end
    submit_valid = 0;
    check("hs_full", 64'(queue_count), 64'(4));
    execution_done = 1; step(); execution_done = 0; step();
    set_desc(9, 9, 1, 1); submit_valid = 1; step(); submit_valid = 0;
    check("hs_full_pop", 64'(queue_count), 64'(3));
    do_reset();
    for (int k = 0; k < 3; k++) begin set_desc(k, k, 1, 1); submit_valid = 1; step(); end
    submit_valid = 0;
    execution_done = 1; step(); execution_done = 0; step();
    set_desc(9, 9, 1, 1); submit_valid = 1; step(); submit_valid = 0;
    check("hs_pushpop", 64'(queue_count), 64'(2));

    // Reset mid-run
    do_reset();
    set_desc(7, 7, 0, 1); submit_valid = 1; step();
    for (int k = 0; k < 4; k++) begin set_desc(k, k, 2, 1); step(); end
    submit_valid = 0;
    check("rm_pre_count", 64'(queue_count), 64'(3));
    check("rm_pre_start", 64'(execution_start), 64'(1));
    reset = 0; step(); reset = 1;
    check("rm_start", 64'(execution_start), 64'(0));
    check("rm_count", 64'(queue_count), 64'(0));
    check("rm_completed", 64'(completed_count), 64'(0));
    check("rm_cfg", 64'(kernel_config), 64'(0));

    // Randomized traffic against the model
    do_reset();
    auto_gpu = 1;
    for (int c = 0; c < 4000; c++) begin
      submit_valid = ($urandom_range(0, 2) != 0);
      set_desc($urandom, $urandom,
               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255),
               $urandom_range(1, 4));
      clear_error = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 999) != 0);
      step();
    end
    reset = 1; clear_error = 0; submit_valid = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
